// File: rtl/prod_bcd_seq_if.sv
// Valid/ready handshake bundle between the multiplier, the BCD converter
// and the display stage.
interface prod_bcd_seq_if #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, busy
  );
endinterface

// File: rtl/prod_bcd_seq.sv
// Sequential double-dabble converter: accepts a binary product, runs IN_W
// shift-add-3 iterations, then holds packed BCD until the consumer takes it.
module prod_bcd_seq #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  prod_bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (pow10(DIGITS) <= ((longint'(1) << IN_W) - 1)) begin : g_bad_params
      $error("prod_bcd_seq: DIGITS too small to hold 2**IN_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_reg;
  logic [IN_W-1:0]     bin_sr_reg;
  logic [BCD_W-1:0]    scratch_reg;
  logic [BCD_W-1:0]    bcd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                out_valid_reg;
  logic                busy_reg;
  logic                in_ready_reg;

  logic [BCD_W-1:0]      adj;
  logic [BCD_W+IN_W-1:0] shifted;

  // Each digit is corrected independently; no carry crosses a digit boundary.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                              ? scratch_reg[gi*4 +: 4] + 4'd3
                              : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adj, bin_sr_reg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bin_sr_reg    <= '0;
      scratch_reg   <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            bin_sr_reg   <= bus.in_data;
            scratch_reg  <= '0;
            cnt_reg      <= CNT_W'(IN_W);
            state_reg    <= SHIFT;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        SHIFT: begin
          scratch_reg <= shifted[BCD_W+IN_W-1:IN_W];
          bin_sr_reg  <= shifted[IN_W-1:0];
          cnt_reg     <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            bcd_reg       <= shifted[BCD_W+IN_W-1:IN_W];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // A concurrent in_valid is deliberately not captured here.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.bcd       = bcd_reg;
  assign bus.busy      = busy_reg;

endmodule
